// File: rtl/unified_cache_miss_replay_queue.sv
// unified_cache_miss_replay_queue
// Per-bank miss buffer: captures main-pipe misses, issues one memory request per
// entry, snoops the bank fill handshake and replays filled packets to the bank
// arbiter. queue_full_out doubles as the replay port's critical flag.
// Optional feature: define UNIFIED_CACHE_MISS_MERGE_EN to merge secondary misses
// onto an outstanding primary for the same block.

`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS 64
`endif
`ifndef UNIFIED_CACHE_BLOCK_SIZE_IN_BYTES
`define UNIFIED_CACHE_BLOCK_SIZE_IN_BYTES 64
`endif

module unified_cache_miss_replay_queue #(
    parameter int NUM_ENTRY         = 4,
    parameter int PACKET_WIDTH      = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS,
    parameter int ADDR_POS_LO       = 0,
    parameter int ADDR_WIDTH        = 32,
    parameter int BLOCK_OFFSET_BITS = $clog2(`UNIFIED_CACHE_BLOCK_SIZE_IN_BYTES)
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic [PACKET_WIDTH-1:0] miss_packet_in,
    input  logic                    miss_packet_valid_in,
    output logic                    miss_packet_ack_out,
    output logic [PACKET_WIDTH-1:0] miss_request_out,
    output logic                    miss_request_valid_out,
    input  logic                    miss_request_ack_in,
    input  logic [PACKET_WIDTH-1:0] fetched_request_in,
    input  logic                    fetched_request_valid_in,
    input  logic                    fetch_ack_in,
    output logic [PACKET_WIDTH-1:0] replay_request_out,
    output logic                    replay_request_valid_out,
    input  logic                    replay_request_ack_in,
    output logic                    queue_full_out
);

    localparam int IDX_W  = $clog2(NUM_ENTRY);
    localparam int CNT_W  = $clog2(NUM_ENTRY + 1);
    localparam int BLK_LO = ADDR_POS_LO + BLOCK_OFFSET_BITS;
    localparam int BLK_W  = ADDR_WIDTH - BLOCK_OFFSET_BITS;

    typedef enum logic [1:0] {
        ST_INVALID,
        ST_PENDING_ISSUE,
        ST_WAIT_FILL,
        ST_READY_REPLAY
    } entry_state_t;

    entry_state_t            r_state [NUM_ENTRY];
    logic [PACKET_WIDTH-1:0] r_pkt   [NUM_ENTRY];
    logic [CNT_W-1:0]        r_count;
    logic                    r_issue_hold;
    logic [IDX_W-1:0]        r_issue_hold_idx;

    logic             w_alloc_found, w_pend_found, w_replay_found;
    logic [IDX_W-1:0] w_alloc_idx, w_pend_idx, w_replay_idx, w_issue_idx;
    logic             w_issue_found;
    logic             w_enq, w_issue_ack, w_fill, w_replay_ack;
    logic [BLK_W-1:0] w_fill_blk, w_miss_blk;
    entry_state_t     w_enq_state;
    logic             w_unused_fill_bits;

    function automatic logic [BLK_W-1:0] blk_of(input logic [PACKET_WIDTH-1:0] p);
        return p[BLK_LO +: BLK_W];
    endfunction

    assign w_fill_blk         = blk_of(fetched_request_in);
    assign w_miss_blk         = blk_of(miss_packet_in);
    assign w_unused_fill_bits = ^fetched_request_in;

    // Lowest-index search for a free slot, an issuable entry and a replayable entry
    always_comb begin
        w_alloc_found  = 1'b0;
        w_alloc_idx    = '0;
        w_pend_found   = 1'b0;
        w_pend_idx     = '0;
        w_replay_found = 1'b0;
        w_replay_idx   = '0;
        for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
            if (!w_alloc_found && r_state[i] == ST_INVALID) begin
                w_alloc_found = 1'b1;
                w_alloc_idx   = IDX_W'(i);
            end
            if (!w_pend_found && r_state[i] == ST_PENDING_ISSUE) begin
                w_pend_found = 1'b1;
                w_pend_idx   = IDX_W'(i);
            end
            if (!w_replay_found && r_state[i] == ST_READY_REPLAY) begin
                w_replay_found = 1'b1;
                w_replay_idx   = IDX_W'(i);
            end
        end
    end

    // A presented-but-unacked request stays on the port even if a lower index
    // becomes pending later, so the payload cannot change under the consumer.
    assign w_issue_found = r_issue_hold | w_pend_found;
    assign w_issue_idx   = r_issue_hold ? r_issue_hold_idx : w_pend_idx;

    assign queue_full_out           = (r_count == CNT_W'(NUM_ENTRY));
    assign miss_packet_ack_out      = !queue_full_out;
    assign miss_request_valid_out   = w_issue_found;
    assign miss_request_out         = w_issue_found ? r_pkt[w_issue_idx] : '0;
    assign replay_request_valid_out = w_replay_found;
    assign replay_request_out       = w_replay_found ? r_pkt[w_replay_idx] : '0;

    assign w_enq        = miss_packet_valid_in & miss_packet_ack_out;
    assign w_issue_ack  = w_issue_found & miss_request_ack_in;
    assign w_fill       = fetched_request_valid_in & fetch_ack_in;
    assign w_replay_ack = w_replay_found & replay_request_ack_in;

`ifdef UNIFIED_CACHE_MISS_MERGE_EN
    logic w_merge_hit, w_merge_ready;

    // Secondary-miss detection against outstanding primaries for the same block
    always_comb begin
        w_merge_hit   = 1'b0;
        w_merge_ready = 1'b0;
        for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
            if ((r_state[i] == ST_PENDING_ISSUE || r_state[i] == ST_WAIT_FILL) &&
                blk_of(r_pkt[i]) == w_miss_blk)
                w_merge_hit = 1'b1;
            if (r_state[i] == ST_WAIT_FILL && blk_of(r_pkt[i]) == w_miss_blk &&
                w_fill && w_fill_blk == w_miss_blk)
                w_merge_ready = 1'b1;
        end
    end

    assign w_enq_state = w_merge_ready ? ST_READY_REPLAY :
                         w_merge_hit   ? ST_WAIT_FILL    : ST_PENDING_ISSUE;
`else
    logic w_unused_miss_blk;
    assign w_unused_miss_blk = ^w_miss_blk;
    assign w_enq_state       = ST_PENDING_ISSUE;
`endif

    // Per-entry lifecycle, occupancy count and issue-port hold
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
                r_state[i] <= ST_INVALID;
                r_pkt[i]   <= '0;
            end
            r_count          <= '0;
            r_issue_hold     <= 1'b0;
            r_issue_hold_idx <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
                case (r_state[i])
                    ST_INVALID:
                        if (w_enq && w_alloc_idx == IDX_W'(i)) begin
                            r_state[i] <= w_enq_state;
                            r_pkt[i]   <= miss_packet_in;
                        end
                    ST_PENDING_ISSUE:
                        if (w_issue_ack && w_issue_idx == IDX_W'(i))
                            r_state[i] <= ST_WAIT_FILL;
                    ST_WAIT_FILL:
                        if (w_fill && blk_of(r_pkt[i]) == w_fill_blk)
                            r_state[i] <= ST_READY_REPLAY;
                    ST_READY_REPLAY:
                        if (w_replay_ack && w_replay_idx == IDX_W'(i))
                            r_state[i] <= ST_INVALID;
                    default:
                        r_state[i] <= ST_INVALID;
                endcase
            end
            r_count          <= r_count + CNT_W'(w_enq) - CNT_W'(w_replay_ack);
            r_issue_hold     <= w_issue_found & !miss_request_ack_in;
            r_issue_hold_idx <= w_issue_idx;
        end
    end

endmodule

// File: tb/tb_unified_cache_miss_replay_queue.sv
// Directed bench for unified_cache_miss_replay_queue (NUM_ENTRY=4, 64-byte blocks).

`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS 64
`endif
`ifndef UNIFIED_CACHE_BLOCK_SIZE_IN_BYTES
`define UNIFIED_CACHE_BLOCK_SIZE_IN_BYTES 64
`endif

module tb_unified_cache_miss_replay_queue;

    localparam int PW = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;

    logic          clk_in;
    logic          reset_in;
    logic [PW-1:0] miss_packet_in;
    logic          miss_packet_valid_in;
    logic          miss_packet_ack_out;
    logic [PW-1:0] miss_request_out;
    logic          miss_request_valid_out;
    logic          miss_request_ack_in;
    logic [PW-1:0] fetched_request_in;
    logic          fetched_request_valid_in;
    logic          fetch_ack_in;
    logic [PW-1:0] replay_request_out;
    logic          replay_request_valid_out;
    logic          replay_request_ack_in;
    logic          queue_full_out;

    int errors = 0;
    int checks = 0;

    unified_cache_miss_replay_queue #(.NUM_ENTRY(4)) dut (
        .clk_in                   (clk_in),
        .reset_in                 (reset_in),
        .miss_packet_in           (miss_packet_in),
        .miss_packet_valid_in     (miss_packet_valid_in),
        .miss_packet_ack_out      (miss_packet_ack_out),
        .miss_request_out         (miss_request_out),
        .miss_request_valid_out   (miss_request_valid_out),
        .miss_request_ack_in      (miss_request_ack_in),
        .fetched_request_in       (fetched_request_in),
        .fetched_request_valid_in (fetched_request_valid_in),
        .fetch_ack_in             (fetch_ack_in),
        .replay_request_out       (replay_request_out),
        .replay_request_valid_out (replay_request_valid_out),
        .replay_request_ack_in    (replay_request_ack_in),
        .queue_full_out           (queue_full_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    function automatic logic [PW-1:0] mk(input int id, input logic [31:0] addr);
        logic [PW-1:0] p;
        p        = '0;
        p[31:0]  = addr;
        p[47:32] = 16'(id);
        return p;
    endfunction

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_inputs;
        miss_packet_in           = '0;
        miss_packet_valid_in     = 1'b0;
        miss_request_ack_in      = 1'b0;
        fetched_request_in       = '0;
        fetched_request_valid_in = 1'b0;
        fetch_ack_in             = 1'b0;
        replay_request_ack_in    = 1'b0;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset_in = 1'b0;
        tick();
        tick();
        reset_in = 1'b1;
        tick();
    endtask

    task automatic enq(input int id, input logic [31:0] addr);
        miss_packet_in       = mk(id, addr);
        miss_packet_valid_in = 1'b1;
    endtask

    task automatic fill(input logic [31:0] addr);
        fetched_request_in       = mk(0, addr);
        fetched_request_valid_in = 1'b1;
        fetch_ack_in             = 1'b1;
    endtask

    task automatic test_reset;
        clear_inputs();
        miss_packet_valid_in = 1'b1;
        reset_in = 1'b0;
        tick();
        tick();
        checks++;
        if (miss_request_valid_out !== 1'b0 || replay_request_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_valids: got req=%b rep=%b want 0 0", miss_request_valid_out, replay_request_valid_out);
        end
        checks++;
        if (miss_packet_ack_out !== 1'b1 || queue_full_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_ack_full: got ack=%b full=%b want 1 0", miss_packet_ack_out, queue_full_out);
        end
        checks++;
        if (miss_request_out !== '0 || replay_request_out !== '0) begin
            errors++;
            $display("FAIL reset_payload: got req=%h rep=%h want 0", miss_request_out, replay_request_out);
        end
        reset_in = 1'b1;
        enq(1, 32'h1000);
        tick();
        clear_inputs();
        checks++;
        if (miss_request_valid_out !== 1'b1) begin
            errors++;
            $display("FAIL pre_midreset_valid: got %b want 1", miss_request_valid_out);
        end
        reset_in = 1'b0;
        #1;
        checks++;
        if (miss_request_valid_out !== 1'b0 || miss_request_out !== '0) begin
            errors++;
            $display("FAIL midreset_drop: got v=%b d=%h want 0 0", miss_request_valid_out, miss_request_out);
        end
        tick();
        reset_in = 1'b1;
        tick();
    endtask

    task automatic test_single_miss;
        do_reset();
        enq(2, 32'h1000);
        tick();
        clear_inputs();
        checks++;
        if (miss_request_valid_out !== 1'b1 || miss_request_out !== mk(2, 32'h1000)) begin
            errors++;
            $display("FAIL single_issue: got v=%b d=%h want 1 %h", miss_request_valid_out, miss_request_out, mk(2, 32'h1000));
        end
        tick();
        tick();
        miss_request_ack_in = 1'b1;
        tick();
        clear_inputs();
        checks++;
        if (miss_request_valid_out !== 1'b0 || replay_request_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL single_after_ack: got req=%b rep=%b want 0 0", miss_request_valid_out, replay_request_valid_out);
        end
        tick();
        tick();
        fill(32'h1000);
        tick();
        clear_inputs();
        checks++;
        if (replay_request_valid_out !== 1'b1 || replay_request_out !== mk(2, 32'h1000)) begin
            errors++;
            $display("FAIL single_replay: got v=%b d=%h want 1 %h", replay_request_valid_out, replay_request_out, mk(2, 32'h1000));
        end
        replay_request_ack_in = 1'b1;
        tick();
        clear_inputs();
        checks++;
        if (replay_request_valid_out !== 1'b0 || miss_request_valid_out !== 1'b0 || queue_full_out !== 1'b0) begin
            errors++;
            $display("FAIL single_empty: got rep=%b req=%b full=%b want 0 0 0", replay_request_valid_out, miss_request_valid_out, queue_full_out);
        end
    endtask

    task automatic test_full;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            enq(10 + k, 32'h3000 + 32'(k) * 32'h40);
            tick();
        end
        enq(14, 32'h3100);
        checks++;
        if (queue_full_out !== 1'b1 || miss_packet_ack_out !== 1'b0) begin
            errors++;
            $display("FAIL full_flag: got full=%b ack=%b want 1 0", queue_full_out, miss_packet_ack_out);
        end
        tick();
        tick();
        checks++;
        if (queue_full_out !== 1'b1 || miss_request_out !== mk(10, 32'h3000)) begin
            errors++;
            $display("FAIL full_held: got full=%b d=%h want 1 %h", queue_full_out, miss_request_out, mk(10, 32'h3000));
        end
        miss_request_ack_in = 1'b1;
        tick();
        miss_request_ack_in = 1'b0;
        checks++;
        if (miss_request_out !== mk(11, 32'h3040)) begin
            errors++;
            $display("FAIL full_next_issue: got %h want %h", miss_request_out, mk(11, 32'h3040));
        end
        fill(32'h3000);
        tick();
        fetched_request_valid_in = 1'b0;
        fetch_ack_in = 1'b0;
        checks++;
        if (replay_request_valid_out !== 1'b1 || queue_full_out !== 1'b1) begin
            errors++;
            $display("FAIL full_replay_ready: got rep=%b full=%b want 1 1", replay_request_valid_out, queue_full_out);
        end
        replay_request_ack_in = 1'b1;
        tick();
        replay_request_ack_in = 1'b0;
        checks++;
        if (queue_full_out !== 1'b0 || miss_packet_ack_out !== 1'b1) begin
            errors++;
            $display("FAIL full_drop: got full=%b ack=%b want 0 1", queue_full_out, miss_packet_ack_out);
        end
        tick();
        miss_packet_valid_in = 1'b0;
        checks++;
        if (queue_full_out !== 1'b1 || miss_request_out !== mk(11, 32'h3040)) begin
            errors++;
            $display("FAIL full_refill_stable: got full=%b d=%h want 1 %h", queue_full_out, miss_request_out, mk(11, 32'h3040));
        end
        miss_request_ack_in = 1'b1;
        tick();
        miss_request_ack_in = 1'b0;
        checks++;
        if (miss_request_out !== mk(14, 32'h3100)) begin
            errors++;
            $display("FAIL full_fifth_issue: got %h want %h", miss_request_out, mk(14, 32'h3100));
        end
    endtask

    task automatic test_stall;
        do_reset();
        enq(20, 32'h4000);
        tick();
        clear_inputs();
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (miss_request_valid_out !== 1'b1 || miss_request_out !== mk(20, 32'h4000)) begin
                errors++;
                $display("FAIL stall_stable[%0d]: got v=%b d=%h want 1 %h", k, miss_request_valid_out, miss_request_out, mk(20, 32'h4000));
            end
            tick();
        end
        fill(32'h2000);
        tick();
        clear_inputs();
        checks++;
        if (miss_request_valid_out !== 1'b1 || miss_request_out !== mk(20, 32'h4000) || replay_request_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL stall_stray_fill: got v=%b d=%h rep=%b want 1 %h 0", miss_request_valid_out, miss_request_out, replay_request_valid_out, mk(20, 32'h4000));
        end
        fill(32'h4000);
        miss_request_ack_in = 1'b1;
        tick();
        clear_inputs();
        checks++;
        if (miss_request_valid_out !== 1'b0 || replay_request_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL issue_fill_same_cycle: got req=%b rep=%b want 0 0", miss_request_valid_out, replay_request_valid_out);
        end
        fill(32'h2000);
        tick();
        fetched_request_in = mk(0, 32'h4000);
        fetch_ack_in = 1'b0;
        tick();
        clear_inputs();
        checks++;
        if (replay_request_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL nomatch_or_unacked_fill: got rep=%b want 0", replay_request_valid_out);
        end
        fill(32'h4020);
        tick();
        clear_inputs();
        checks++;
        if (replay_request_valid_out !== 1'b1 || replay_request_out !== mk(20, 32'h4000)) begin
            errors++;
            $display("FAIL block_offset_fill: got v=%b d=%h want 1 %h", replay_request_valid_out, replay_request_out, mk(20, 32'h4000));
        end
    endtask

    task automatic test_merge;
        do_reset();
        enq(30, 32'h1000);
        tick();
        enq(31, 32'h1010);
        tick();
        clear_inputs();
        checks++;
        if (miss_request_valid_out !== 1'b1 || miss_request_out !== mk(30, 32'h1000)) begin
            errors++;
            $display("FAIL merge_first_req: got v=%b d=%h want 1 %h", miss_request_valid_out, miss_request_out, mk(30, 32'h1000));
        end
        miss_request_ack_in = 1'b1;
        tick();
        miss_request_ack_in = 1'b0;
`ifdef UNIFIED_CACHE_MISS_MERGE_EN
        checks++;
        if (miss_request_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL merge_single_request: got v=%b want 0", miss_request_valid_out);
        end
`else
        checks++;
        if (miss_request_valid_out !== 1'b1 || miss_request_out !== mk(31, 32'h1010)) begin
            errors++;
            $display("FAIL nomerge_second_req: got v=%b d=%h want 1 %h", miss_request_valid_out, miss_request_out, mk(31, 32'h1010));
        end
        miss_request_ack_in = 1'b1;
        tick();
        miss_request_ack_in = 1'b0;
`endif
        fill(32'h1000);
        tick();
        clear_inputs();
        checks++;
        if (replay_request_valid_out !== 1'b1 || replay_request_out !== mk(30, 32'h1000)) begin
            errors++;
            $display("FAIL merge_replay0: got v=%b d=%h want 1 %h", replay_request_valid_out, replay_request_out, mk(30, 32'h1000));
        end
        replay_request_ack_in = 1'b1;
        tick();
        checks++;
        if (replay_request_valid_out !== 1'b1 || replay_request_out !== mk(31, 32'h1010)) begin
            errors++;
            $display("FAIL merge_replay1: got v=%b d=%h want 1 %h", replay_request_valid_out, replay_request_out, mk(31, 32'h1010));
        end
        tick();
        replay_request_ack_in = 1'b0;
        checks++;
        if (replay_request_valid_out !== 1'b0 || miss_request_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL merge_drained: got rep=%b req=%b want 0 0", replay_request_valid_out, miss_request_valid_out);
        end
`ifdef UNIFIED_CACHE_MISS_MERGE_EN
        enq(32, 32'h8000);
        tick();
        clear_inputs();
        miss_request_ack_in = 1'b1;
        tick();
        clear_inputs();
        enq(33, 32'h8020);
        fill(32'h8000);
        tick();
        clear_inputs();
        checks++;
        if (replay_request_out !== mk(32, 32'h8000) || miss_request_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL merge_fill_same_cycle0: got d=%h req=%b want %h 0", replay_request_out, miss_request_valid_out, mk(32, 32'h8000));
        end
        replay_request_ack_in = 1'b1;
        tick();
        replay_request_ack_in = 1'b0;
        checks++;
        if (replay_request_valid_out !== 1'b1 || replay_request_out !== mk(33, 32'h8020)) begin
            errors++;
            $display("FAIL merge_fill_same_cycle1: got v=%b d=%h want 1 %h", replay_request_valid_out, replay_request_out, mk(33, 32'h8020));
        end
`endif
    endtask

    task automatic test_simultaneous;
        do_reset();
        enq(40, 32'h6000);
        tick();
        enq(41, 32'h6040);
        tick();
        clear_inputs();
        miss_request_ack_in = 1'b1;
        tick();
        tick();
        clear_inputs();
        checks++;
        if (miss_request_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL sim_both_issued: got v=%b want 0", miss_request_valid_out);
        end
        fill(32'h6000);
        tick();
        clear_inputs();
        checks++;
        if (replay_request_out !== mk(40, 32'h6000)) begin
            errors++;
            $display("FAIL sim_replay0: got %h want %h", replay_request_out, mk(40, 32'h6000));
        end
        replay_request_ack_in = 1'b1;
        enq(42, 32'h7000);
        fill(32'h6040);
        tick();
        clear_inputs();
        checks++;
        if (replay_request_valid_out !== 1'b1 || replay_request_out !== mk(41, 32'h6040)) begin
            errors++;
            $display("FAIL sim_entry1_ready: got v=%b d=%h want 1 %h", replay_request_valid_out, replay_request_out, mk(41, 32'h6040));
        end
        checks++;
        if (miss_request_valid_out !== 1'b1 || miss_request_out !== mk(42, 32'h7000)) begin
            errors++;
            $display("FAIL sim_new_pending: got v=%b d=%h want 1 %h", miss_request_valid_out, miss_request_out, mk(42, 32'h7000));
        end
        enq(43, 32'h7040);
        tick();
        checks++;
        if (queue_full_out !== 1'b0) begin
            errors++;
            $display("FAIL sim_count3: got full=%b want 0", queue_full_out);
        end
        enq(44, 32'h7080);
        tick();
        clear_inputs();
        checks++;
        if (queue_full_out !== 1'b1) begin
            errors++;
            $display("FAIL sim_count4: got full=%b want 1", queue_full_out);
        end
    endtask

    initial begin
        clear_inputs();
        reset_in = 1'b0;
        test_reset();
        test_single_miss();
        test_full();
        test_stall();
        test_merge();
        test_simultaneous();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
